// File: rtl/led_pkg.sv
// Shared definitions for the LED fade driver: default PWM width and duty range helper.
package led_pkg;

  localparam int PWM_BITS_DEF = 8;

  typedef logic [PWM_BITS_DEF-1:0] duty_t;

  // Full-scale duty for a given counter width (2^bits - 1).
  function automatic int pwm_max(input int bits);
    return (1 << bits) - 1;
  endfunction

endpackage

// File: rtl/led_fade_driver_if.sv
// Pattern/control inputs and PWM/status outputs of the LED fade driver.
interface led_fade_driver_if #(
  parameter int NUM_LEDS = 8
);

  logic                enable;
  logic [NUM_LEDS-1:0] pattern_in;
  logic [NUM_LEDS-1:0] led_out;
  logic                busy;
  logic                period_start;

  modport master (
    output enable, pattern_in,
    input  led_out, busy, period_start
  );

  modport slave (
    input  enable, pattern_in,
    output led_out, busy, period_start
  );

endinterface

// File: rtl/led_fade_channel.sv
// One LED channel: duty register ramped toward full on/off with saturation, plus PWM compare.
module led_fade_channel #(
  parameter int PWM_BITS = 8,
  parameter int STEP     = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                step,
  input  logic                target_on,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led,
  output logic                busy
);
  import led_pkg::*;

  localparam int MAX = pwm_max(PWM_BITS);
  localparam int W1  = PWM_BITS + 1;

  logic [PWM_BITS-1:0] duty_reg;
  logic [PWM_BITS-1:0] duty_next;
  logic                led_reg;
  logic [W1-1:0]       up_sum;
  logic [W1-1:0]       down_diff;

  // One extra bit: overflow past MAX or borrow below 0 both clamp instead of wrapping.
  always_comb begin
    up_sum    = {1'b0, duty_reg} + W1'(STEP);
    down_diff = {1'b0, duty_reg} - W1'(STEP);
    duty_next = duty_reg;
    if (step) begin
      if (target_on) begin
        duty_next = (up_sum > W1'(MAX)) ? PWM_BITS'(MAX) : up_sum[PWM_BITS-1:0];
      end else begin
        duty_next = down_diff[PWM_BITS] ? '0 : down_diff[PWM_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_reg <= '0;
      led_reg  <= 1'b0;
    end else begin
      duty_reg <= duty_next;
      led_reg  <= enable & (duty_reg > pwm_cnt);
    end
  end

  assign led  = led_reg;
  assign busy = target_on ? (duty_reg != PWM_BITS'(MAX)) : (duty_reg != '0);

endmodule

// File: rtl/led_fade_driver.sv
// LED fade driver: shared prescaler, PWM and ramp counters feeding NUM_LEDS fading channels.
module led_fade_driver
  import led_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int PRESCALE = 50,
  parameter int RAMP_DIV = 4,
  parameter int STEP     = 1
) (
  input logic               clk,
  input logic               reset_n,
  led_fade_driver_if.slave  bus
);

  localparam int MAX    = pwm_max(PWM_BITS);
  localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [NUM_LEDS-1:0] pattern_reg;
  logic [PRE_W-1:0]    pre_cnt_reg;
  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic [RAMP_W-1:0]   ramp_cnt_reg;
  logic                period_start_reg;
  logic                tick;
  logic                wrap;
  logic                step;
  logic [NUM_LEDS-1:0] led_vec;
  logic [NUM_LEDS-1:0] busy_vec;

  assign tick = bus.enable && (pre_cnt_reg == PRE_W'(PRESCALE - 1));
  assign wrap = tick && (pwm_cnt_reg == PWM_BITS'(MAX - 1));
  assign step = wrap && (ramp_cnt_reg == RAMP_W'(RAMP_DIV - 1));

  // Steps land only on a pwm wrap, so duty never changes in the middle of a period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_reg      <= '0;
      pre_cnt_reg      <= '0;
      pwm_cnt_reg      <= '0;
      ramp_cnt_reg     <= '0;
      period_start_reg <= 1'b0;
    end else begin
      pattern_reg      <= bus.pattern_in;
      period_start_reg <= wrap;
      if (tick) begin
        pre_cnt_reg <= '0;
        pwm_cnt_reg <= wrap ? '0 : pwm_cnt_reg + PWM_BITS'(1);
        if (wrap) begin
          ramp_cnt_reg <= step ? '0 : ramp_cnt_reg + RAMP_W'(1);
        end
      end else if (bus.enable) begin
        pre_cnt_reg <= pre_cnt_reg + PRE_W'(1);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
    led_fade_channel #(
      .PWM_BITS (PWM_BITS),
      .STEP     (STEP)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (bus.enable),
      .step      (step),
      .target_on (pattern_reg[gi]),
      .pwm_cnt   (pwm_cnt_reg),
      .led       (led_vec[gi]),
      .busy      (busy_vec[gi])
    );
  end

  assign bus.led_out      = led_vec;
  assign bus.busy         = |busy_vec;
  assign bus.period_start = period_start_reg;

endmodule

// File: tb/tb_led_fade_driver.sv
// Scoreboard bench: two driver configurations share stimulus and are checked every clk against a timeline model.
module tb_led_fade_driver;

  localparam int NL   = 8;
  localparam int PB   = 4;
  localparam int PS   = 2;
  localparam int MAXV = 15;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable;
  logic [NL-1:0] pattern;

  int errors = 0;
  int checks = 0;
  int seg_no = 0;

  always #5 clk = ~clk;

  led_fade_driver_if #(.NUM_LEDS(NL)) bus_a ();
  led_fade_driver_if #(.NUM_LEDS(NL)) bus_b ();

  assign bus_a.enable     = enable;
  assign bus_a.pattern_in = pattern;
  assign bus_b.enable     = enable;
  assign bus_b.pattern_in = pattern;

  led_fade_driver #(.NUM_LEDS(NL), .PWM_BITS(PB), .PRESCALE(PS), .RAMP_DIV(1), .STEP(5)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a.slave)
  );

  led_fade_driver #(.NUM_LEDS(NL), .PWM_BITS(PB), .PRESCALE(PS), .RAMP_DIV(2), .STEP(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b.slave)
  );

  typedef struct packed {
    logic [NL-1:0] led_a;
    logic          busy_a;
    logic          ps_a;
    logic [NL-1:0] led_b;
    logic          busy_b;
    logic          ps_b;
  } exp_t;

  exp_t exp_q[$];

  // Model state: enabled-clock count gives the position in the PWM timeline directly.
  int            en_clks [2];
  logic [NL-1:0] patq_m  [2];
  int            duty_m  [2][NL];
  logic [NL-1:0] led_m   [2];
  logic          ps_m    [2];

  function automatic int step_of(input int k);
    return (k == 0) ? 5 : 4;
  endfunction

  function automatic int rdiv_of(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic logic busy_of(input int k);
    logic b = 1'b0;
    for (int i = 0; i < NL; i++) begin
      if (duty_m[k][i] != (patq_m[k][i] ? MAXV : 0)) b = 1'b1;
    end
    return b;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      en_clks[k] = 0;
      patq_m[k]  = '0;
      led_m[k]   = '0;
      ps_m[k]    = 1'b0;
      for (int i = 0; i < NL; i++) duty_m[k][i] = 0;
    end
  endtask

  task automatic model_edge(input logic en, input logic [NL-1:0] pat);
    int pos;
    int done_wraps;
    int tgt;
    logic tick_m;
    logic wrap_m;
    logic stp;
    for (int k = 0; k < 2; k++) begin
      pos        = (en_clks[k] / PS) % MAXV;
      tick_m     = en && ((en_clks[k] % PS) == PS - 1);
      wrap_m     = tick_m && (pos == MAXV - 1);
      done_wraps = en_clks[k] / (PS * MAXV);
      stp        = wrap_m && ((done_wraps % rdiv_of(k)) == rdiv_of(k) - 1);
      for (int i = 0; i < NL; i++) begin
        led_m[k][i] = en && (duty_m[k][i] > pos);
        if (stp) begin
          tgt = patq_m[k][i] ? MAXV : 0;
          if (duty_m[k][i] < tgt)
            duty_m[k][i] = (duty_m[k][i] + step_of(k) > MAXV) ? MAXV : duty_m[k][i] + step_of(k);
          else if (duty_m[k][i] > tgt)
            duty_m[k][i] = (duty_m[k][i] - step_of(k) < 0) ? 0 : duty_m[k][i] - step_of(k);
        end
      end
      ps_m[k]   = wrap_m;
      patq_m[k] = pat;
      if (en) en_clks[k] = en_clks[k] + 1;
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.led_a  = led_m[0];
    e.busy_a = busy_of(0);
    e.ps_a   = ps_m[0];
    e.led_b  = led_m[1];
    e.busy_b = busy_of(1);
    e.ps_b   = ps_m[1];
    return e;
  endfunction

  // One clk of stimulus; the expected post-edge response is queued at that edge.
  task automatic cycle(input logic en, input logic [NL-1:0] pat);
    enable  = en;
    pattern = pat;
    @(posedge clk);
    if (reset_n) model_edge(en, pat);
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic seg(input logic en, input logic [NL-1:0] pat, input int n);
    $display("seg %0d: enable=%b pattern=%h clks=%0d", seg_no, en, pat, n);
    seg_no++;
    for (int c = 0; c < n; c++) cycle(en, pat);
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if ({bus_a.led_out, bus_a.busy, bus_a.period_start} !== '0) begin
      errors++;
      $display("FAIL %s_a: got led=%h busy=%b ps=%b, want all 0", tag,
               bus_a.led_out, bus_a.busy, bus_a.period_start);
    end
    checks++;
    if ({bus_b.led_out, bus_b.busy, bus_b.period_start} !== '0) begin
      errors++;
      $display("FAIL %s_b: got led=%h busy=%b ps=%b, want all 0", tag,
               bus_b.led_out, bus_b.busy, bus_b.period_start);
    end
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before the next edge.
  task automatic do_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    $display("reset asserted mid-run at %0t", $time);
    for (int c = 0; c < 3; c++) cycle(enable, pattern);
    reset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    if (exp_q.size() > 0) begin
      e          = exp_q.pop_front();
      got.led_a  = bus_a.led_out;
      got.busy_a = bus_a.busy;
      got.ps_a   = bus_a.period_start;
      got.led_b  = bus_b.led_out;
      got.busy_b = bus_b.busy;
      got.ps_b   = bus_b.period_start;
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL outputs @%0t: got a(led=%h busy=%b ps=%b) b(led=%h busy=%b ps=%b), want a(led=%h busy=%b ps=%b) b(led=%h busy=%b ps=%b)",
                 $time, got.led_a, got.busy_a, got.ps_a, got.led_b, got.busy_b, got.ps_b,
                 e.led_a, e.busy_a, e.ps_a, e.led_b, e.busy_b, e.ps_b);
      end
    end
  end

  initial begin
    logic          r_en;
    logic [NL-1:0] r_pat;
    int            r_len;
    enable  = 1'b0;
    pattern = '0;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_zero("power_on_reset");
    for (int c = 0; c < 3; c++) cycle(1'b0, '0);
    reset_n = 1'b1;

    seg(1'b1, 8'h01, 120);   // fade in channel 0
    seg(1'b1, 8'h00, 70);    // reversal back to dark
    seg(1'b1, 8'h01, 37);
    seg(1'b0, 8'h01, 20);    // freeze mid-period
    seg(1'b1, 8'h01, 40);
    seg(1'b1, 8'hFF, 300);   // all channels to saturation
    seg(1'b1, 8'h00, 45);
    do_reset();              // mid-ramp reset
    seg(1'b1, 8'h5A, 200);

    for (int s = 0; s < 40; s++) begin
      r_en  = ($urandom_range(0, 4) != 0);
      r_pat = NL'($urandom);
      r_len = $urandom_range(1, 90);
      seg(r_en, r_pat, r_len);
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
